// File: rtl/mvm_pkg.sv
// Shared definitions for the streaming matrix-vector multiply core:
// opcodes, FSM state encoding, accumulator sizing and signed saturation.
package mvm_pkg;

  localparam logic [7:0] OP_LOAD_K  = 8'hA0;
  localparam logic [7:0] OP_COMPUTE = 8'hB0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_LOAD_X,
    ST_MAC,
    ST_SEND
  } state_e;

  // Accumulator width that can hold C full-scale products without overflow.
  function automatic int calc_w_acc(input int w_x, input int w_k, input int c);
    return w_x + w_k + $clog2(c);
  endfunction

  // Clamp v into the signed range of width w and return it sign-extended to a byte.
  function automatic logic signed [7:0] sat_to_byte(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return 8'(r);
  endfunction

endpackage

// File: rtl/mvm_mac_sat.sv
// Signed multiply-accumulate with clear/enable; the running sum is saturated
// combinationally to W_Y_OUT bits and presented sign-extended to a byte.
module mvm_mac_sat
  import mvm_pkg::*;
#(
  parameter int C       = 2,
  parameter int W_X     = 4,
  parameter int W_K     = 4,
  parameter int W_Y_OUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic signed [W_K-1:0] k_i,
  input  logic signed [W_X-1:0] x_i,
  output logic        [7:0]     y_byte_o
);

  localparam int W_P   = W_X + W_K;
  localparam int W_ACC = calc_w_acc(W_X, W_K, C);

  logic signed [W_P-1:0]   k_ext;
  logic signed [W_P-1:0]   x_ext;
  logic signed [W_P-1:0]   prod;
  logic signed [W_ACC-1:0] acc_d;
  logic signed [W_ACC-1:0] acc_q;

  // Product and next accumulator value; clear wins over enable.
  always_comb begin
    k_ext = W_P'(k_i);
    x_ext = W_P'(x_i);
    prod  = k_ext * x_ext;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + W_ACC'(prod);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Saturated view of the accumulator.
  always_comb begin
    y_byte_o = sat_to_byte(32'(acc_q), W_Y_OUT);
  end

endmodule

// File: rtl/mvm_stream_core.sv
// Byte-stream matrix-vector engine: loads K once, then streams x vectors
// and returns R saturated y bytes per COMPUTE command.
module mvm_stream_core
  import mvm_pkg::*;
#(
  parameter int R       = 2,
  parameter int C       = 2,
  parameter int W_X     = 4,
  parameter int W_K     = 4,
  parameter int W_Y_OUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       k_loaded,
  output logic       busy,
  output logic       cmd_err
);

  localparam int N_K   = R * C;
  localparam int IDX_W = (N_K > 1) ? $clog2(N_K) : 1;
  localparam int COL_W = (C > 1) ? $clog2(C) : 1;
  localparam int ROW_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_K - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(C - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(R - 1);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic signed [W_K-1:0] k_q [N_K];
  logic signed [W_K-1:0] k_d [N_K];
  logic signed [W_X-1:0] x_q [C];
  logic signed [W_X-1:0] x_d [C];
  logic k_loaded_q, k_loaded_d;
  logic cmd_err_q, cmd_err_d;
  logic s_fire, m_fire, mac_clr, mac_en;
  logic [IDX_W-1:0] k_sel;
  logic [7:0] y_byte;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s_fire && s_data == OP_LOAD_K)       state_d = ST_LOAD_K;
        else if (s_fire && s_data == OP_COMPUTE) state_d = ST_LOAD_X;
      end
      ST_LOAD_K: if (s_fire && idx_q == IDX_LAST) state_d = ST_IDLE;
      ST_LOAD_X: if (s_fire && col_q == COL_LAST) state_d = ST_MAC;
      ST_MAC:    if (col_q == COL_LAST)           state_d = ST_SEND;
      ST_SEND:   if (m_fire)                      state_d = (row_q == ROW_LAST) ? ST_IDLE : ST_MAC;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs and status flags derived from the current state.
  always_comb begin
    s_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD_K) || (state_q == ST_LOAD_X);
    m_valid  = (state_q == ST_SEND);
    busy     = (state_q == ST_MAC) || (state_q == ST_SEND);
    s_fire   = s_valid && s_ready;
    m_fire   = m_valid && m_ready;
    m_data   = y_byte;
    k_loaded = k_loaded_q;
    cmd_err  = cmd_err_q;
  end

  // Counters, operand storage and accumulator control per state.
  always_comb begin
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    k_d        = k_q;
    x_d        = x_q;
    k_loaded_d = k_loaded_q;
    cmd_err_d  = cmd_err_q;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_fire && s_data != OP_LOAD_K && s_data != OP_COMPUTE) cmd_err_d = 1'b1;
      end
      ST_LOAD_K: begin
        if (s_fire) begin
          k_d[idx_q] = s_data[W_K-1:0];
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            k_loaded_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LOAD_X: begin
        if (s_fire) begin
          x_d[col_q] = s_data[W_X-1:0];
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = '0;
            mac_clr = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        col_d  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
      ST_SEND: begin
        if (m_fire) begin
          if (row_q == ROW_LAST) begin
            row_d = '0;
          end else begin
            row_d   = row_q + 1'b1;
            mac_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Counter, operand and flag registers; reset discards any partial command.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      k_loaded_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      for (int i = 0; i < N_K; i++) k_q[i] <= '0;
      for (int i = 0; i < C; i++)   x_q[i] <= '0;
    end else begin
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      k_loaded_q <= k_loaded_d;
      cmd_err_q  <= cmd_err_d;
      k_q        <= k_d;
      x_q        <= x_d;
    end
  end

  // Row-major element select for the current MAC step.
  always_comb begin
    k_sel = IDX_W'(int'(row_q) * C + int'(col_q));
  end

  mvm_mac_sat #(
    .C      (C),
    .W_X    (W_X),
    .W_K    (W_K),
    .W_Y_OUT(W_Y_OUT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .k_i     (k_q[k_sel]),
    .x_i     (x_q[col_q]),
    .y_byte_o(y_byte)
  );

endmodule

// File: doc/mvm_stream_core.md
# mvm_stream_core

Parametrised matrix-vector multiply engine: y = K·x, with signed operands and saturating outputs. It sits between the UART RX byte stream and the UART TX byte stream in the MVM UART system. It generalises the fixed 2×2, unsigned, single-shot datapath to any R×C size. The matrix stays loaded in the core, so any number of x vectors can be streamed against it. Commands arrive in-band as opcode bytes.

## Interface
Parameters:
- R, 2: output rows (≥1).
- C, 2: input columns (≥1).
- W_X, 4: signed x element width (2..8).
- W_K, 4: signed K element width (2..8).
- W_Y_OUT, 8: signed saturated y width (2..8).

Ports:
- clk, in, 1: the only clock.
- rst, in, 1: reset, synchronous, active-high.
- s_data, in, 8: byte from UART RX.
- s_valid, in, 1: s_data is valid.
- s_ready, out, 1: core accepts a byte this cycle.
- m_data, out, 8: y byte to UART TX.
- m_valid, out, 1: m_data is valid.
- m_ready, in, 1: TX accepts the byte.
- k_loaded, out, 1: a complete K has been loaded since reset.
- busy, out, 1: core is in MAC or SEND.
- cmd_err, out, 1: sticky; set when an unknown opcode is received.

## Operation
- A byte is accepted when s_valid && s_ready on a rising clk edge. The output transfer rule is the same: m_valid && m_ready.
- Opcodes, decoded only in IDLE:
  - 0xA0 LOAD_K: the next R·C bytes are K, row-major.
  - 0xB0 COMPUTE: the next C bytes are x[0..C-1]; the core then emits R bytes y[0..R-1].
  - Any other byte sets cmd_err, is discarded, and the core stays in IDLE.
- Element extraction: K uses s_data[W_K-1:0] and x uses s_data[W_X-1:0], both two's complement. Upper bits are ignored.
- FSM states:
  - IDLE → LOAD_K on 0xA0; IDLE → LOAD_X on 0xB0.
  - LOAD_K: an index counter runs 0..R·C-1. On the last byte, k_loaded goes to 1 and the state returns to IDLE.
  - LOAD_X: a counter runs 0..C-1. The last byte → MAC with row=0, col=0, acc=0.
  - MAC: one product per cycle, acc += K[row][col]·x[col]. After col=C-1 → SEND.
  - SEND: holds the saturated result. On handshake, if row<R-1 → MAC with row+1 and acc=0; otherwise → IDLE.
- Arithmetic:
  - Product width is W_X+W_K. Accumulator width is W_ACC = W_X+W_K+clog2(C), so it never overflows.
  - Saturation bounds are [-2^(W_Y_OUT-1), 2^(W_Y_OUT-1)-1].
  - m_data is the saturated value sign-extended to 8 bits.
- K persists across COMPUTE commands. A LOAD_K overwrites K element by element. k_loaded stays 1 from the first complete load until reset.
- COMPUTE without a prior LOAD_K is legal: K is zero, so the output is R bytes of 0x00.
- Reset (at any time, including mid-load, mid-MAC or mid-SEND):
  - State becomes IDLE; all counters, acc, K and x clear to 0.
  - k_loaded=0, cmd_err=0, m_valid=0.
  - Any partial command is lost.

## Timing
- Output values one cycle after reset: s_ready=1, m_valid=0, m_data=0x00, busy=0, k_loaded=0, cmd_err=0.
- s_ready=1 in IDLE, LOAD_K and LOAD_X. s_ready=0 in MAC and SEND; input bytes presented then are neither consumed nor dropped.
- Let t be the cycle in which the last x byte is accepted:
  - MAC occupies cycles t+1..t+C.
  - m_valid=1 from cycle t+C+1 for row 0.
- After the row-r handshake at cycle u, row r+1 is in MAC for cycles u+1..u+C and has m_valid at u+C+1. m_valid is 0 during MAC.
- While m_valid=1 && m_ready=0, m_data is held stable and m_valid stays high. m_ready may be held high continuously.
- After the last row's handshake at cycle u, the state is IDLE at u+1 and s_ready=1. A new opcode can be accepted at u+1.
- busy = (state==MAC || state==SEND), registered with the state.
- cmd_err is set in the cycle after the bad opcode is accepted.

## Structure
- Shared package mvm_pkg holds:
  - The opcode constants OP_LOAD_K=8'hA0 and OP_COMPUTE=8'hB0.
  - The FSM state enum.
  - The W_ACC calculation function and a signed saturate function.
- One sub-module, mvm_mac_sat. It holds a signed W_K×W_X multiply, the W_ACC accumulator with clear/enable, and the combinational saturation to W_Y_OUT.
- The top holds the FSM, row/col/index counters, the K register array (R·C·W_K bits) and the x register array (C·W_X bits).

## Test plan
- Identity, defaults: send A0 01 00 00 01, then B0 03 0E. Expect m_data 0x03 then 0xFE, and k_loaded=1. The first m_valid appears 3 cycles after the last x byte.
- Saturation, defaults: send A0 07 07 08 08, then B0 08 08. Row0 = -112 → 0x90; row1 = +128 → 0x7F.
- Persistence and backpressure: after one LOAD_K, run two COMPUTEs with different x. Both results must be correct. Hold m_ready=0 for 10 cycles: m_valid and m_data stay stable and s_ready=0 throughout.
- Bad opcode and unloaded K: from reset, send 0x55. Expect cmd_err=1, no output, and s_ready still 1. Then send B0 05 05: expect 0x00 0x00 and k_loaded still 0.
- Reset mid-operation: assert rst during SEND of row 0. One cycle later, all outputs are at reset values, and COMPUTE then returns zeros.
- Parameter sweep R=3, C=4, W_X=W_K=8, W_Y_OUT=8: run random K and x against a reference model with saturation, using random m_ready/s_valid gaps, over 200 vectors.
